// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS memory-stage types and decode helpers
package mips_pkg;

  typedef enum logic [3:0] {
    MEM_NONE = 4'd0,
    MEM_LB   = 4'd1,
    MEM_LBU  = 4'd2,
    MEM_LH   = 4'd3,
    MEM_LHU  = 4'd4,
    MEM_LW   = 4'd5,
    MEM_LWL  = 4'd6,
    MEM_LWR  = 4'd7,
    MEM_SB   = 4'd8,
    MEM_SH   = 4'd9,
    MEM_SW   = 4'd10
  } mem_op_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_CAP,
    ST_WR,
    ST_DONE
  } mem_state_t;

  localparam logic [3:0] MEM_OP_MAX = 4'd10;

  function automatic logic is_misaligned(input mem_op_t op, input logic [1:0] k);
    case (op)
      MEM_LH, MEM_LHU, MEM_SH: return k[0];
      MEM_LW, MEM_SW:          return (k != 2'd0);
      default:                 return 1'b0;
    endcase
  endfunction

  function automatic logic is_store(input mem_op_t op);
    return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - little-endian lane extraction for loads and
// byte/halfword merge for read-modify-write stores
module mem_lane_align
  import mips_pkg::*;
(
  input  mem_op_t     op,
  input  logic [1:0]  k,
  input  logic [31:0] w,
  input  logic [31:0] rt,
  output logic [31:0] load_data,
  output logic [31:0] store_data
);

  logic [4:0]  sh_r;
  logic [4:0]  sh_l;
  logic [31:0] w_shr;

  // 8*(3-k) equals {~k,3'b000} for a 2-bit k
  assign sh_r  = {k, 3'b000};
  assign sh_l  = {~k, 3'b000};
  assign w_shr = w >> sh_r;

  always_comb begin
    load_data = w;
    case (op)
      MEM_LB:  load_data = {{24{w_shr[7]}}, w_shr[7:0]};
      MEM_LBU: load_data = {24'h0, w_shr[7:0]};
      MEM_LH:  load_data = {{16{w_shr[15]}}, w_shr[15:0]};
      MEM_LHU: load_data = {16'h0, w_shr[15:0]};
      MEM_LWL: load_data = (w << sh_l) | (rt & ~(32'hFFFF_FFFF << sh_l));
      MEM_LWR: load_data = w_shr | (rt & ~(32'hFFFF_FFFF >> sh_r));
      default: load_data = w;
    endcase
  end

  always_comb begin
    store_data = w;
    case (op)
      MEM_SB:  store_data = (w & ~(32'h0000_00FF << sh_r)) | ({24'h0, rt[7:0]} << sh_r);
      MEM_SH:  store_data = (w & ~(32'h0000_FFFF << sh_r)) | ({16'h0, rt[15:0]} << sh_r);
      MEM_SW:  store_data = rt;
      default: store_data = w;
    endcase
  end

endmodule

// File: rtl/harvard_mem_access.sv
// rtl/harvard_mem_access.sv - multicycle memory-access stage over a word-only
// data bus; sub-word stores are done as read-modify-write
module harvard_mem_access
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [3:0]  mem_op,
  input  logic [31:0] addr,
  input  logic [31:0] rt_data,
  input  logic [31:0] data_readdata,
  output logic [31:0] data_address,
  output logic        data_read,
  output logic        data_write,
  output logic [31:0] data_writedata,
  output logic [31:0] result,
  output logic        fault,
  output logic        done,
  output logic        busy
);

  mem_state_t  state_q, state_d;
  mem_op_t     op_q, op_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] rt_q, rt_d;
  logic [31:0] w_q, w_d;
  logic [31:0] result_q, result_d;
  logic        fault_q, fault_d;

  mem_op_t     in_op;
  logic        in_fault;
  logic [31:0] lane_w;
  logic [31:0] load_data;
  logic [31:0] store_data;

  assign in_op    = mem_op_t'(mem_op);
  assign in_fault = is_misaligned(in_op, addr[1:0]);
  // During CAP the word is still on the bus; use it so result lands at the end of CAP
  assign lane_w   = (state_q == ST_CAP) ? data_readdata : w_q;

  mem_lane_align u_lane (
    .op         (op_q),
    .k          (addr_q[1:0]),
    .w          (lane_w),
    .rt         (rt_q),
    .load_data  (load_data),
    .store_data (store_data)
  );

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    addr_d   = addr_q;
    rt_d     = rt_q;
    w_d      = w_q;
    result_d = result_q;
    fault_d  = fault_q;
    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          op_d    = in_op;
          addr_d  = addr;
          rt_d    = rt_data;
          fault_d = in_fault;
          // Undefined opcodes complete like MEM_NONE
          if (in_fault || in_op == MEM_NONE || mem_op > MEM_OP_MAX) state_d = ST_DONE;
          else if (in_op == MEM_SW)                                 state_d = ST_WR;
          else                                                      state_d = ST_RD;
        end
      end
      ST_RD:   state_d = ST_CAP;
      ST_CAP: begin
        w_d = data_readdata;
        if (is_store(op_q)) begin
          state_d = ST_WR;
        end else begin
          result_d = load_data;
          state_d  = ST_DONE;
        end
      end
      ST_WR:   state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      op_q     <= MEM_NONE;
      addr_q   <= 32'h0;
      rt_q     <= 32'h0;
      w_q      <= 32'h0;
      result_q <= 32'h0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      addr_q   <= addr_d;
      rt_q     <= rt_d;
      w_q      <= w_d;
      result_q <= result_d;
      fault_q  <= fault_d;
    end
  end

  assign data_read      = (state_q == ST_RD);
  assign data_write     = (state_q == ST_WR);
  assign data_address   = (data_read || data_write) ? {addr_q[31:2], 2'b00} : 32'h0;
  assign data_writedata = data_write ? store_data : 32'h0;
  assign result         = result_q;
  assign fault          = fault_q;
  assign done           = (state_q == ST_DONE);
  assign busy           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_harvard_mem_access.sv
// tb/tb_harvard_mem_access.sv - scoreboard bench for harvard_mem_access
module tb_harvard_mem_access;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [3:0]  mem_op = 4'd0;
  logic [31:0] addr = 32'h0;
  logic [31:0] rt_data = 32'h0;
  logic [31:0] data_readdata = 32'h0;
  logic [31:0] data_address;
  logic        data_read;
  logic        data_write;
  logic [31:0] data_writedata;
  logic [31:0] result;
  logic        fault;
  logic        done;
  logic        busy;

  harvard_mem_access dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .mem_op         (mem_op),
    .addr           (addr),
    .rt_data        (rt_data),
    .data_readdata  (data_readdata),
    .data_address   (data_address),
    .data_read      (data_read),
    .data_write     (data_write),
    .data_writedata (data_writedata),
    .result         (result),
    .fault          (fault),
    .done           (done),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    int          lat;
    logic        flt;
    logic [31:0] res;
    int          rd_lat;
    int          wr_lat;
    logic [31:0] baddr;
    logic [31:0] wdata;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          start_cyc = 0;
  int          rd_seen = 0;
  int          wr_seen = 0;
  int          wr_total = 0;
  int          n;
  logic [31:0] mem_word = 32'h0;
  logic [31:0] last_res = 32'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) data_readdata <= data_read ? mem_word : 32'h0;

  // Monitor: compares bus activity and completion against the queue head
  always @(negedge clk) begin
    if (!reset) begin
      if (data_write) wr_total++;
      if (data_read && data_write) chk("strobe_excl", 32'd1, 32'd0);
      if (exp_q.size() > 0) begin
        n = cyc - start_cyc + 1;
        if (data_read) begin
          rd_seen++;
          if (rd_seen == 1) begin
            chk({exp_q[0].tag, ".rd_lat"}, n, exp_q[0].rd_lat);
            chk({exp_q[0].tag, ".rd_addr"}, data_address, exp_q[0].baddr);
          end
        end
        if (data_write) begin
          wr_seen++;
          chk({exp_q[0].tag, ".wr_lat"}, n, exp_q[0].wr_lat);
          chk({exp_q[0].tag, ".wr_addr"}, data_address, exp_q[0].baddr);
          chk({exp_q[0].tag, ".wr_data"}, data_writedata, exp_q[0].wdata);
        end
        if (done) begin
          exp_t e;
          e = exp_q.pop_front();
          chk({e.tag, ".done_lat"}, n, e.lat);
          chk({e.tag, ".fault"}, fault, e.flt);
          chk({e.tag, ".result"}, result, e.res);
          chk({e.tag, ".nrd"}, rd_seen, (e.rd_lat > 0) ? 1 : 0);
          chk({e.tag, ".nwr"}, wr_seen, (e.wr_lat > 0) ? 1 : 0);
          rd_seen = 0;
          wr_seen = 0;
        end
      end else begin
        if (data_write) chk("unexpected_write", 32'd1, 32'd0);
        if (done) chk("unexpected_done", 32'd1, 32'd0);
      end
    end
  end

  task automatic do_op(input string tag, input mem_op_t op, input logic [31:0] a,
                       input logic [31:0] rt, input logic [31:0] word, input int lat,
                       input logic flt, input logic [31:0] res, input int rdl,
                       input int wrl, input logic [31:0] wd);
    exp_t e;
    bit   ok;
    e.tag = tag; e.lat = lat; e.flt = flt; e.res = res;
    e.rd_lat = rdl; e.wr_lat = wrl; e.baddr = {a[31:2], 2'b00}; e.wdata = wd;
    @(negedge clk);
    mem_word = word;
    exp_q.push_back(e);
    mem_op = op; addr = a; rt_data = rt; enable = 1'b1;
    start_cyc = cyc + 1;
    @(negedge clk);
    enable = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      chk({tag, ".timeout"}, 32'd1, 32'd0);
      exp_q.delete();
      rd_seen = 0;
      wr_seen = 0;
    end
    last_res = res;
  endtask

  initial begin
    int wr_before;
    repeat (3) @(negedge clk);
    chk("rst.data_read", data_read, 1'b0);
    chk("rst.data_write", data_write, 1'b0);
    chk("rst.done", done, 1'b0);
    chk("rst.fault", fault, 1'b0);
    chk("rst.busy", busy, 1'b0);
    chk("rst.data_address", data_address, 32'h0);
    chk("rst.data_writedata", data_writedata, 32'h0);
    chk("rst.result", result, 32'h0);
    reset = 1'b0;

    do_op("lb",     MEM_LB,   32'h1003, 32'h0,        32'h80FF7F01, 3, 1'b0, 32'hFFFFFF80, 1, 0, 32'h0);
    do_op("lbu",    MEM_LBU,  32'h1003, 32'h0,        32'h80FF7F01, 3, 1'b0, 32'h00000080, 1, 0, 32'h0);
    do_op("lb_k0",  MEM_LB,   32'h1000, 32'h0,        32'h80FF7F01, 3, 1'b0, 32'h00000001, 1, 0, 32'h0);
    do_op("lh",     MEM_LH,   32'h2002, 32'h0,        32'hBEEF1234, 3, 1'b0, 32'hFFFFBEEF, 1, 0, 32'h0);
    do_op("lh_mis", MEM_LH,   32'h2001, 32'h0,        32'hBEEF1234, 1, 1'b1, last_res,     0, 0, 32'h0);
    do_op("sb",     MEM_SB,   32'h3001, 32'h000000AA, 32'h11223344, 4, 1'b0, last_res,     1, 3, 32'h1122AA44);
    do_op("sw",     MEM_SW,   32'h4000, 32'hDEADBEEF, 32'h0,        2, 1'b0, last_res,     0, 1, 32'hDEADBEEF);
    do_op("lwl",    MEM_LWL,  32'h5001, 32'hAABBCCDD, 32'h44332211, 3, 1'b0, 32'h2211CCDD, 1, 0, 32'h0);
    do_op("lwr",    MEM_LWR,  32'h5002, 32'hAABBCCDD, 32'h44332211, 3, 1'b0, 32'hAABB4433, 1, 0, 32'h0);
    do_op("lhu",    MEM_LHU,  32'h2002, 32'h0,        32'hBEEF1234, 3, 1'b0, 32'h0000BEEF, 1, 0, 32'h0);
    do_op("sh",     MEM_SH,   32'h6002, 32'h00005566, 32'h11223344, 4, 1'b0, last_res,     1, 3, 32'h55663344);
    do_op("lw",     MEM_LW,   32'h7004, 32'h0,        32'h12345678, 3, 1'b0, 32'h12345678, 1, 0, 32'h0);
    do_op("sw_mis", MEM_SW,   32'h4002, 32'h0,        32'h0,        1, 1'b1, last_res,     0, 0, 32'h0);
    do_op("none",   MEM_NONE, 32'h0,    32'h0,        32'h0,        1, 1'b0, last_res,     0, 0, 32'h0);

    // Reset during the RD cycle of an SB: no write may follow
    wr_before = wr_total;
    @(negedge clk);
    mem_word = 32'h11223344;
    mem_op = MEM_SB; addr = 32'h3001; rt_data = 32'h000000AA; enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    chk("rstsb.in_rd", data_read, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    chk("rstsb.busy", busy, 1'b0);
    chk("rstsb.data_read", data_read, 1'b0);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    chk("rstsb.no_write", wr_total - wr_before, 32'd0);
    do_op("lw_post", MEM_LW, 32'h8000, 32'h0, 32'hCAFEF00D, 3, 1'b0, 32'hCAFEF00D, 1, 0, 32'h0);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
